// File: rtl/cvxif_custom_responder.sv
// CV-X-IF coprocessor responder: decodes custom-3 ADD/MUL/NOP, keeps a 2-entry
// in-order queue and returns results only for committed instructions.
module cvxif_custom_responder #(
    parameter int XLEN       = 32,
    parameter int IdWidth    = 3,
    parameter int MulLatency = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               x_issue_valid_i,
    output logic               x_issue_ready_o,
    input  logic [31:0]        x_issue_instr_i,
    input  logic [IdWidth-1:0] x_issue_id_i,
    input  logic [XLEN-1:0]    x_issue_rs1_i,
    input  logic [XLEN-1:0]    x_issue_rs2_i,
    input  logic [1:0]         x_issue_rs_valid_i,
    output logic               x_issue_accept_o,
    output logic               x_issue_writeback_o,
    input  logic               x_commit_valid_i,
    input  logic [IdWidth-1:0] x_commit_id_i,
    input  logic               x_commit_kill_i,
    output logic               x_result_valid_o,
    input  logic               x_result_ready_i,
    output logic [IdWidth-1:0] x_result_id_o,
    output logic [XLEN-1:0]    x_result_data_o,
    output logic [4:0]         x_result_rd_o,
    output logic               x_result_we_o
);
    localparam int         CntW        = $clog2(MulLatency + 1);
    localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;

    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_MUL = 2'd1, OP_NOP = 2'd2} op_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_e;

    logic [IdWidth-1:0] r_q_id  [2];
    op_e                r_q_op  [2];
    logic [XLEN-1:0]    r_q_rs1 [2];
    logic [XLEN-1:0]    r_q_rs2 [2];
    logic [4:0]         r_q_rd  [2];
    logic [1:0]         r_q_cm;
    logic [1:0]         r_q_kl;
    logic               r_head;
    logic [1:0]         r_count;

    state_e             r_state;
    logic [CntW-1:0]    r_cnt;
    logic               r_res_valid;
    logic [IdWidth-1:0] r_res_id;
    logic [XLEN-1:0]    r_res_data;
    logic [4:0]         r_res_rd;
    logic               r_res_we;

    op_e             w_dec_op;
    logic            w_legal;
    logic            w_ops_ok;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_wr_slot;
    logic            w_new_hit;
    logic            w_head_kl;
    op_e             w_head_op;
    logic [1:0]      w_slot_vld;
    logic [1:0]      w_cm_nxt;
    logic [1:0]      w_kl_nxt;
    logic [XLEN-1:0] w_exec_res;
    logic            w_unused_bits;

    assign w_unused_bits = ^x_issue_instr_i[31:15];

    // Instruction decode of the offered word.
    always_comb begin
        w_dec_op = OP_NOP;
        w_legal  = 1'b0;
        if (x_issue_instr_i[6:0] == OPC_CUSTOM3) begin
            case (x_issue_instr_i[14:12])
                3'd0:    begin w_dec_op = OP_ADD; w_legal = 1'b1; end
                3'd1:    begin w_dec_op = OP_MUL; w_legal = 1'b1; end
                3'd2:    begin w_dec_op = OP_NOP; w_legal = 1'b1; end
                default: begin w_dec_op = OP_NOP; w_legal = 1'b0; end
            endcase
        end else begin
            w_legal = 1'b0;
        end
    end

    // Ready ignores a same-cycle pop so a full queue never accepts.
    assign w_ops_ok            = (w_dec_op == OP_NOP) || (x_issue_rs_valid_i == 2'b11);
    assign w_full              = (r_count == 2'd2);
    assign x_issue_ready_o     = x_issue_valid_i && (!w_legal || (!w_full && w_ops_ok));
    assign x_issue_accept_o    = x_issue_valid_i && w_legal;
    assign x_issue_writeback_o = x_issue_valid_i && w_legal && (w_dec_op != OP_NOP);
    assign w_push              = x_issue_valid_i && w_legal && !w_full && w_ops_ok;
    assign w_wr_slot           = r_head ^ r_count[0];
    assign w_new_hit           = x_commit_valid_i && (x_commit_id_i == x_issue_id_i);
    assign w_head_kl           = (r_count != 2'd0) && r_q_kl[r_head];
    assign w_head_op           = (r_count != 2'd0) ? r_q_op[r_head] : w_dec_op;
    assign w_pop               = w_head_kl ||
                                 ((r_state == ST_DONE) && r_res_valid && x_result_ready_i);

    // Next commit/kill flags; only the first decision for an id sticks.
    always_comb begin
        w_slot_vld = 2'b00;
        w_cm_nxt   = r_q_cm;
        w_kl_nxt   = r_q_kl;
        for (int i = 0; i < 2; i++) begin
            w_slot_vld[i] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'(i)));
            if (w_push && (w_wr_slot == 1'(i))) begin
                w_cm_nxt[i] = w_new_hit && !x_commit_kill_i;
                w_kl_nxt[i] = w_new_hit && x_commit_kill_i;
            end else if (w_slot_vld[i] && x_commit_valid_i && (x_commit_id_i == r_q_id[i]) &&
                         !r_q_cm[i] && !r_q_kl[i]) begin
                w_cm_nxt[i] = !x_commit_kill_i;
                w_kl_nxt[i] = x_commit_kill_i;
            end else begin
                w_cm_nxt[i] = r_q_cm[i];
                w_kl_nxt[i] = r_q_kl[i];
            end
        end
    end

    // Execution datapath for the head entry.
    always_comb begin
        case (r_q_op[r_head])
            OP_ADD:  w_exec_res = r_q_rs1[r_head] + r_q_rs2[r_head];
            OP_MUL:  w_exec_res = r_q_rs1[r_head] * r_q_rs2[r_head];
            default: w_exec_res = {XLEN{1'b0}};
        endcase
    end

    // Queue storage, pointers and decision flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            r_q_cm  <= 2'b00;
            r_q_kl  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_q_id[i]  <= {IdWidth{1'b0}};
                r_q_op[i]  <= OP_NOP;
                r_q_rs1[i] <= {XLEN{1'b0}};
                r_q_rs2[i] <= {XLEN{1'b0}};
                r_q_rd[i]  <= 5'd0;
            end
        end else begin
            r_head <= r_head ^ w_pop;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            r_q_cm <= w_cm_nxt;
            r_q_kl <= w_kl_nxt;
            if (w_push) begin
                r_q_id[w_wr_slot]  <= x_issue_id_i;
                r_q_op[w_wr_slot]  <= w_dec_op;
                r_q_rs1[w_wr_slot] <= x_issue_rs1_i;
                r_q_rs2[w_wr_slot] <= x_issue_rs2_i;
                r_q_rd[w_wr_slot]  <= x_issue_instr_i[11:7];
            end
        end
    end

    // Head FSM; an empty queue lets a fresh push start executing at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CntW{1'b0}};
            r_res_valid <= 1'b0;
            r_res_id    <= {IdWidth{1'b0}};
            r_res_data  <= {XLEN{1'b0}};
            r_res_rd    <= 5'd0;
            r_res_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_res_valid <= 1'b0;
                    if (!w_head_kl && ((r_count != 2'd0) || w_push)) begin
                        r_state <= ST_EXEC;
                        r_cnt   <= (w_head_op == OP_MUL) ? CntW'(MulLatency) : CntW'(1);
                    end
                end
                ST_EXEC: begin
                    if (w_head_kl) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CntW'(1)) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= w_cm_nxt[r_head];
                        r_res_id    <= r_q_id[r_head];
                        r_res_data  <= w_exec_res;
                        r_res_rd    <= r_q_rd[r_head];
                        r_res_we    <= (r_q_op[r_head] != OP_NOP);
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                ST_DONE: begin
                    if (w_pop) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                    end else if (!r_res_valid) begin
                        r_res_valid <= w_cm_nxt[r_head];
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign x_result_valid_o = r_res_valid;
    assign x_result_id_o    = r_res_id;
    assign x_result_data_o  = r_res_data;
    assign x_result_rd_o    = r_res_rd;
    assign x_result_we_o    = r_res_we;

endmodule

// File: doc/cvxif_custom_responder.md
# cvxif_custom_responder

Coprocessor-side responder for the CORE-V eXtension Interface (CV-X-IF) that the 32-bit FPGA core drives as initiator. It decodes a small custom instruction set in the custom-3 opcode space, holds accepted instructions in a 2-entry in-order queue, and executes them. Results are returned only for committed instructions; killed instructions are discarded. It attaches directly to the core's CV-X-IF issue, commit and result channels.

## Interface
- XLEN, 32, operand/result width
- IdWidth, 3, instruction ID width (log2 of 8 scoreboard entries)
- MulLatency, 3, cycles from a multiply becoming head to result ready (>=1)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- x_issue_valid_i  in  1  core offers an instruction
- x_issue_ready_o  out  1  responder takes the offer this cycle
- x_issue_instr_i  in  32  instruction word
- x_issue_id_i  in  IdWidth  instruction ID
- x_issue_rs1_i / x_issue_rs2_i  in  XLEN  source operands
- x_issue_rs_valid_i  in  2  operand valid flags [1]=rs2, [0]=rs1
- x_issue_accept_o  out  1  instruction is ours; meaningful only on issue handshake
- x_issue_writeback_o  out  1  accepted instruction will write rd
- x_commit_valid_i  in  1  commit/kill decision valid
- x_commit_id_i  in  IdWidth  ID being committed or killed
- x_commit_kill_i  in  1  1 = kill, 0 = commit
- x_result_valid_o  out  1  result offered
- x_result_ready_i  in  1  core takes result
- x_result_id_o  out  IdWidth  result ID
- x_result_data_o  out  XLEN  result value
- x_result_rd_o  out  5  destination register
- x_result_we_o  out  1  write rd

## Operation
- Decode: opcode 7'b1111011 required. funct3=0 CUS_ADD (rd=rs1+rs2, mod 2^XLEN), funct3=1 CUS_MUL (rd=low XLEN bits of rs1*rs2, unsigned), funct3=2 CUS_NOP (we=0, no rd write). Anything else is illegal.
- Illegal instruction: ready=1 whenever valid, accept=0, writeback=0, nothing enqueued, regardless of queue state.
- Legal: ready=1 only when queue not full and rs_valid[1:0]=2'b11 (NOP needs no operands). accept=1; writeback=1 for ADD/MUL.
- Queue entry: id, op, rs1, rs2, rd, committed, killed. Push on legal handshake; in-order pop at head.
- Commit: matched against every valid entry by id (including an entry pushed in the same cycle). Unmatched ids are ignored. A second commit for the same id is ignored.
- Head FSM:
  - IDLE: entry at head and not killed -> EXEC, counter loaded (ADD/NOP=1, MUL=MulLatency).
  - EXEC: decrement; at 1 latch result -> DONE.
  - DONE: wait for committed. Then x_result_valid_o=1; on valid&ready pop -> IDLE.
  - A killed head in any state is popped the next edge without a result, -> IDLE.
- NOP produces a result transaction with we=0 and data=0.

## Timing
- Reset values: all outputs 0, queue empty, FSM IDLE. Asynchronous assertion clears state mid-operation, including a pending result.
- Issue response is combinational in the handshake cycle.
- Minimum issue-to-result latency: ADD 2 cycles (head next cycle, DONE the following), MUL MulLatency+1, with the commit already received.
- Result valid stays high, with id/data/rd/we stable, until ready. It never drops without a handshake except on reset.
- Full queue: legal offers see ready=0. A pop and a push in the same cycle are allowed only when the queue was not full before the pop; ready does not depend on the same-cycle pop.
- A kill arriving while the head is in DONE with valid asserted is illegal per protocol; ignore it if it occurs after commit.

## Test plan
- Reset, then ADD id=1 rs1=5 rs2=7 rd=3, commit id=1 same cycle -> accept=1, writeback=1; result 2 cycles later: id=1 data=12 rd=3 we=1.
- MUL 0xFFFF_FFFF*2 id=2, commit 5 cycles later -> result data=0xFFFF_FFFE appears only after the commit, at the earliest MulLatency+1 after issue.
- Issue 2 ADDs back to back, hold result_ready=0 -> third legal offer sees ready=0. After two result handshakes, order is id0 then id1.
- Illegal opcode 0x00000013 with the queue full -> ready=1, accept=0; no result is ever produced.
- ADD id=4 killed during EXEC, MUL id=5 committed -> only id=5 result appears; id=4 never appears.
- rst_ni pulsed low while result_valid=1 -> all outputs 0 immediately; the queue is empty after release.
